// File: rtl/aes_inv_key_scheduler.sv
// -----------------------------------------------------------------------------
// aes_inv_key_scheduler
//
// Sequential AES-128 inverse key scheduler for the decryption datapath.
// A key is loaded either as the cipher key (expanded forward internally for
// ten cycles) or directly as the round-10 key. Round keys are then emitted
// in descending order, round 10 down to round 0, one per valid/ready handshake.
//
// Ports:
//   i_clk            single clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_load_valid     key load request (only honoured while o_load_ready)
//   o_load_ready     high only when idle
//   i_load_is_final  1: i_load_key is the round-10 key, 0: it is the cipher key
//   i_load_key       key, word w0 in [127:96] ... w3 in [31:0]
//   o_key_valid      o_round_key / o_round_idx are valid
//   i_key_ready      consumer accepts the current round key
//   o_round_key      current round key, same word order as i_load_key
//   o_round_idx      round number of o_round_key (10..0)
//   o_key_last       high with o_key_valid for round 0
// -----------------------------------------------------------------------------
module aes_inv_key_scheduler (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load_valid,
    output logic         o_load_ready,
    input  logic         i_load_is_final,
    input  logic [127:0] i_load_key,
    output logic         o_key_valid,
    input  logic         i_key_ready,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_key_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_EMIT
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Division by x in GF(2^8): undoes xtime so Rcon can walk backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;

    logic [31:0]  w_k0, w_k1, w_k2, w_k3;
    logic [31:0]  w_inv3;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_t;
    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;

    assign {w_k0, w_k1, w_k2, w_k3} = r_key;

    // The inverse step needs the recovered w3 before it can rebuild w0, so
    // the single shared SubWord is fed either the current w3 (forward) or
    // the recovered w3 (inverse).
    assign w_inv3   = w_k3 ^ w_k2;
    assign w_sub_in = (r_state == S_FWD) ? w_k3 : w_inv3;
    assign w_t      = sub_word(rot_word(w_sub_in)) ^ {r_rcon, 24'h000000};

    assign w_f0      = w_k0 ^ w_t;
    assign w_f1      = w_k1 ^ w_f0;
    assign w_f2      = w_k2 ^ w_f1;
    assign w_f3      = w_k3 ^ w_f2;
    assign w_fwd_key = {w_f0, w_f1, w_f2, w_f3};

    assign w_inv_key = {w_k0 ^ w_t, w_k1 ^ w_k0, w_k2 ^ w_k1, w_inv3};

    assign o_round_key = r_key;
    assign o_round_idx = r_round;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_load_ready = 1'b0;
        o_key_valid  = 1'b0;
        o_key_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_load_ready = 1'b1;
                if (i_load_valid) begin
                    w_state_next = i_load_is_final ? S_EMIT : S_FWD;
                end
            end
            S_FWD: begin
                // Round 9 -> 10 is the last forward step.
                if (r_round == 4'd9) begin
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                o_key_valid = 1'b1;
                o_key_last  = (r_round == 4'd0);
                if (i_key_ready && (r_round == 4'd0)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_key   <= 128'h0;
            r_round <= 4'd0;
            r_rcon  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_valid) begin
                        r_key   <= i_load_key;
                        r_round <= i_load_is_final ? 4'd10 : 4'd0;
                        r_rcon  <= i_load_is_final ? 8'h36 : 8'h01;
                    end
                end
                S_FWD: begin
                    r_key   <= w_fwd_key;
                    r_round <= r_round + 4'd1;
                    // Re-arm Rcon for the first inverse step (round 10 -> 9).
                    r_rcon  <= (r_round == 4'd9) ? 8'h36 : xtime(r_rcon);
                end
                S_EMIT: begin
                    if (i_key_ready && (r_round != 4'd0)) begin
                        r_key   <= w_inv_key;
                        r_round <= r_round - 4'd1;
                        r_rcon  <= inv_xtime(r_rcon);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_scheduler
//
// Self-checking bench for aes_inv_key_scheduler. The reference model builds
// the S-box from GF(2^8) inversion plus the affine map and runs the textbook
// forward AES-128 key expansion; expected emissions are its round keys in
// reverse order.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_scheduler;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_load_valid;
    logic         o_load_ready;
    logic         i_load_is_final;
    logic [127:0] i_load_key;
    logic         o_key_valid;
    logic         i_key_ready;
    logic [127:0] o_round_key;
    logic [3:0]   o_round_idx;
    logic         o_key_last;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   modelSbox [256];
    logic [127:0] expRk [11];
    logic [127:0] obsKey [16];
    logic [3:0]   obsIdx [16];
    logic         obsLast [16];

    aes_inv_key_scheduler dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_load_valid    (i_load_valid),
        .o_load_ready    (o_load_ready),
        .i_load_is_final (i_load_is_final),
        .i_load_key      (i_load_key),
        .o_key_valid     (o_key_valid),
        .i_key_ready     (i_key_ready),
        .o_round_key     (o_round_key),
        .o_round_idx     (o_round_idx),
        .o_key_last      (o_key_last)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            modelSbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                           ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {modelSbox[temp[31:24]], modelSbox[temp[23:16]],
                        modelSbox[temp[15:8]], modelSbox[temp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            expRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_load(input logic [127:0] key, input logic isFinal);
        i_load_valid    = 1'b1;
        i_load_key      = key;
        i_load_is_final = isFinal;
        tick();
        i_load_valid    = 1'b0;
    endtask

    task automatic wait_valid(input bit poke, output int lat, output int readySeen);
        lat = 1;
        readySeen = 0;
        while (!o_key_valid && lat < 40) begin
            if (poke) begin
                i_load_valid    = 1'b1;
                i_load_key      = {$urandom, $urandom, $urandom, $urandom};
                i_load_is_final = 1'($urandom);
            end
            if (o_load_ready) readySeen++;
            tick();
            lat++;
        end
        i_load_valid = 1'b0;
    endtask

    task automatic drain_keys(input int readyPct, input bit poke,
                              output int n, output int cycles, output int readySeen);
        n = 0;
        cycles = 0;
        readySeen = 0;
        while (n < 11 && cycles < 300) begin
            i_key_ready = ($urandom_range(99) < readyPct);
            if (poke) begin
                i_load_valid    = 1'b1;
                i_load_key      = {$urandom, $urandom, $urandom, $urandom};
                i_load_is_final = 1'($urandom);
            end
            if (o_load_ready) readySeen++;
            if (o_key_valid && i_key_ready) begin
                obsKey[n]  = o_round_key;
                obsIdx[n]  = o_round_idx;
                obsLast[n] = o_key_last;
                n++;
            end
            tick();
            cycles++;
        end
        i_load_valid = 1'b0;
        i_key_ready  = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        checks++;
        if (o_load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_load_ready: got %b expected 1", o_load_ready); end
        checks++;
        if (o_key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_valid: got %b expected 0", o_key_valid); end
        checks++;
        if (o_key_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_last: got %b expected 0", o_key_last); end
        checks++;
        if (o_round_key !== 128'h0) begin failures++; $display("[TB] FAIL reset_round_key: got %h expected 0", o_round_key); end
        checks++;
        if (o_round_idx !== 4'd0) begin failures++; $display("[TB] FAIL reset_round_idx: got %0d expected 0", o_round_idx); end
    endtask

    task automatic test_fips_cipher();
        int lat, rs, n, cyc;
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start_load(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        wait_valid(1'b0, lat, rs);
        checks++;
        if (lat != 11) begin failures++; $display("[TB] FAIL fips_cipher_latency: got %0d expected 11", lat); end
        drain_keys(100, 1'b0, n, cyc, rs);
        checks++;
        if (n != 11 || cyc != 11) begin failures++; $display("[TB] FAIL fips_cipher_throughput: got %0d keys in %0d cycles expected 11 in 11", n, cyc); end
        checks++;
        if (obsKey[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || obsIdx[0] !== 4'd10) begin
            failures++; $display("[TB] FAIL fips_round10: got %h idx %0d expected d014f9a8c9ee2589e13f0cc8b6630ca6 idx 10", obsKey[0], obsIdx[0]);
        end
        checks++;
        if (obsKey[9] !== 128'ha0fafe1788542cb123a339392a6c7605 || obsIdx[9] !== 4'd1) begin
            failures++; $display("[TB] FAIL fips_round1: got %h idx %0d expected a0fafe1788542cb123a339392a6c7605 idx 1", obsKey[9], obsIdx[9]);
        end
        checks++;
        if (obsKey[10] !== 128'h2b7e151628aed2a6abf7158809cf4f3c || obsLast[10] !== 1'b1) begin
            failures++; $display("[TB] FAIL fips_round0: got %h last %b expected 2b7e151628aed2a6abf7158809cf4f3c last 1", obsKey[10], obsLast[10]);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i) || obsLast[i] !== (i == 10)) begin
                failures++; $display("[TB] FAIL fips_cipher_seq[%0d]: got %h idx %0d last %b expected %h idx %0d", i, obsKey[i], obsIdx[i], obsLast[i], expRk[10-i], 10-i);
            end
        end
        checks++;
        if (o_key_valid !== 1'b0 || o_load_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL fips_after_last: got valid %b ready %b expected valid 0 ready 1", o_key_valid, o_load_ready);
        end
    endtask

    task automatic test_fips_final();
        int lat, rs, n, cyc;
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start_load(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        wait_valid(1'b0, lat, rs);
        checks++;
        if (lat != 1) begin failures++; $display("[TB] FAIL fips_final_latency: got %0d expected 1", lat); end
        drain_keys(100, 1'b0, n, cyc, rs);
        checks++;
        if (n != 11 || cyc != 11) begin failures++; $display("[TB] FAIL fips_final_throughput: got %0d keys in %0d cycles expected 11 in 11", n, cyc); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i) || obsLast[i] !== (i == 10)) begin
                failures++; $display("[TB] FAIL fips_final_seq[%0d]: got %h idx %0d last %b expected %h idx %0d", i, obsKey[i], obsIdx[i], obsLast[i], expRk[10-i], 10-i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] key;
        int lat, rs, n, cyc;
        bit stalled;
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(key, 1'b0);
        wait_valid(1'b0, lat, rs);
        n = 0;
        cyc = 0;
        stalled = 0;
        while (n < 11 && cyc < 100) begin
            if (!stalled && o_round_idx == 4'd7) begin
                for (int s = 0; s < 5; s++) begin
                    i_key_ready = 1'b0;
                    tick();
                    checks++;
                    if (o_key_valid !== 1'b1 || o_round_key !== expRk[7] || o_round_idx !== 4'd7 || o_key_last !== 1'b0) begin
                        failures++; $display("[TB] FAIL stall_hold[%0d]: got valid %b key %h idx %0d expected valid 1 key %h idx 7", s, o_key_valid, o_round_key, o_round_idx, expRk[7]);
                    end
                end
                stalled = 1;
            end
            i_key_ready = 1'b1;
            checks++;
            if (o_key_valid !== 1'b1 || o_round_key !== expRk[10-n] || o_round_idx !== 4'(10-n)) begin
                failures++; $display("[TB] FAIL stall_seq[%0d]: got valid %b key %h idx %0d expected key %h idx %0d", n, o_key_valid, o_round_key, o_round_idx, expRk[10-n], 10-n);
            end
            tick();
            n++;
            cyc++;
        end
        checks++;
        if (!stalled || o_key_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_done: got stalled %0d valid %b expected stalled 1 valid 0", stalled, o_key_valid); end
    endtask

    task automatic test_load_ignored();
        logic [127:0] key;
        int lat, rs, n, cyc;
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(key, 1'b0);
        wait_valid(1'b1, lat, rs);
        checks++;
        if (lat != 11 || rs != 0) begin failures++; $display("[TB] FAIL ignore_fwd: got latency %0d ready_cycles %0d expected 11 and 0", lat, rs); end
        drain_keys(100, 1'b1, n, cyc, rs);
        checks++;
        if (n != 11 || rs != 0) begin failures++; $display("[TB] FAIL ignore_emit: got keys %0d ready_cycles %0d expected 11 and 0", n, rs); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i)) begin
                failures++; $display("[TB] FAIL ignore_seq[%0d]: got %h idx %0d expected %h idx %0d", i, obsKey[i], obsIdx[i], expRk[10-i], 10-i);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] key;
        int lat, rs, n, cyc;
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(key, 1'b0);
        tick();
        tick();
        tick();
        // reset during the 4th forward step, with a competing load request
        i_reset         = 1'b1;
        i_load_valid    = 1'b1;
        i_load_is_final = 1'b1;
        i_load_key      = expRk[10];
        tick();
        i_reset      = 1'b0;
        i_load_valid = 1'b0;
        checks++;
        if (o_key_valid !== 1'b0 || o_load_ready !== 1'b1 || o_round_key !== 128'h0 || o_round_idx !== 4'd0 || o_key_last !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_fwd: got valid %b ready %b key %h idx %0d last %b expected reset values", o_key_valid, o_load_ready, o_round_key, o_round_idx, o_key_last);
        end
        tick();
        checks++;
        if (o_key_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_fwd_quiet: got valid %b expected 0", o_key_valid); end

        start_load(expRk[10], 1'b1);
        i_key_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        i_key_ready = 1'b0;
        checks++;
        if (o_round_idx !== 4'd6 || o_round_key !== expRk[6]) begin
            failures++; $display("[TB] FAIL abort_pre_emit: got idx %0d key %h expected idx 6 key %h", o_round_idx, o_round_key, expRk[6]);
        end
        i_reset = 1'b1;
        tick();
        i_reset     = 1'b0;
        i_key_ready = 1'b1;
        checks++;
        if (o_key_valid !== 1'b0 || o_load_ready !== 1'b1 || o_round_key !== 128'h0 || o_round_idx !== 4'd0 || o_key_last !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_emit: got valid %b ready %b key %h idx %0d last %b expected reset values", o_key_valid, o_load_ready, o_round_key, o_round_idx, o_key_last);
        end

        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(key, 1'b0);
        wait_valid(1'b0, lat, rs);
        drain_keys(100, 1'b0, n, cyc, rs);
        checks++;
        if (lat != 11 || n != 11) begin failures++; $display("[TB] FAIL abort_reload: got latency %0d keys %0d expected 11 and 11", lat, n); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i)) begin
                failures++; $display("[TB] FAIL abort_seq[%0d]: got %h idx %0d expected %h idx %0d", i, obsKey[i], obsIdx[i], expRk[10-i], 10-i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] key;
        int lat, rs, n, cyc;
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(expRk[10], 1'b1);
        drain_keys(100, 1'b0, n, cyc, rs);
        checks++;
        if (o_load_ready !== 1'b1 || o_key_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_ready: got ready %b valid %b expected 1 0", o_load_ready, o_key_valid);
        end
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
        start_load(key, 1'b0);
        wait_valid(1'b0, lat, rs);
        checks++;
        if (lat != 11) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 11", lat); end
        drain_keys(100, 1'b0, n, cyc, rs);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i) || obsLast[i] !== (i == 10)) begin
                failures++; $display("[TB] FAIL b2b_seq[%0d]: got %h idx %0d last %b expected %h idx %0d", i, obsKey[i], obsIdx[i], obsLast[i], expRk[10-i], 10-i);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic         isFinal;
        int lat, rs, n, cyc;
        for (int t = 0; t < 4; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            isFinal = 1'($urandom);
            expand_key(key);
            start_load(isFinal ? expRk[10] : key, isFinal);
            wait_valid(1'b0, lat, rs);
            checks++;
            if (lat != (isFinal ? 1 : 11)) begin
                failures++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, isFinal ? 1 : 11);
            end
            drain_keys(60, 1'b0, n, cyc, rs);
            checks++;
            if (n != 11) begin failures++; $display("[TB] FAIL rand_count[%0d]: got %0d expected 11", t, n); end
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (obsKey[i] !== expRk[10-i] || obsIdx[i] !== 4'(10-i) || obsLast[i] !== (i == 10)) begin
                    failures++; $display("[TB] FAIL rand_seq[%0d][%0d]: got %h idx %0d last %b expected %h idx %0d", t, i, obsKey[i], obsIdx[i], obsLast[i], expRk[10-i], 10-i);
                end
            end
        end
    endtask

    initial begin
        i_reset         = 1'b1;
        i_load_valid    = 1'b0;
        i_load_is_final = 1'b0;
        i_load_key      = 128'h0;
        i_key_ready     = 1'b1;
        build_sbox();
        test_reset();
        test_fips_cipher();
        test_fips_final();
        test_backpressure();
        test_load_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_scheduler.md
# aes_inv_key_scheduler

Sequential AES-128 inverse key scheduler for the decryption datapath. It emits round keys in descending order, round 10 down to round 0, one per handshake. Round constants run from 0x36 down to 0x01. It accepts either the cipher key, in which case it first expands forward internally, or a precomputed round-10 key.

## Interface
- No parameters. AES-128 only: Nk = 4, Nr = 10.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  key load request
- load_ready  out  1  high only in IDLE
- load_is_final  in  1  1: load_key is the round-10 key; 0: load_key is the cipher key
- load_key  in  128  key word w0 in bits [127:96], w3 in bits [31:0]
- key_valid  out  1  round_key/round_idx valid
- key_ready  in  1  consumer accepts the current round key
- round_key  out  128  current round key, same word order as load_key
- round_idx  out  4  round number of round_key, 10..0
- key_last  out  1  high with key_valid when round_idx = 0

## Operation
- States:
  - IDLE: no key held.
  - FWD: internal forward expansion; no output.
  - EMIT: presenting a round key.
- IDLE:
  - load_ready = 1.
  - On load_valid with load_is_final = 1: key_reg <= load_key, round <= 10, rcon <= 0x36, next state EMIT.
  - On load_valid with load_is_final = 0: key_reg <= load_key, round <= 0, rcon <= 0x01, next state FWD.
- FWD, one step per cycle:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - round <= round+1; rcon <= xtime(rcon).
  - On the step that makes round = 10: rcon <= 0x36, next state EMIT.
- EMIT:
  - key_valid = 1; round_key = key_reg; round_idx = round.
  - On key_valid & key_ready with round = 0: next state IDLE.
  - On key_valid & key_ready with round ≠ 0, inverse step:
    - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon, 24'h0}.
    - round <= round-1; rcon <= inv_xtime(rcon).
- Arithmetic:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 0x1b : 0).
  - inv_xtime(x) = x[0] ? ({1'b0,x[7:1]} ^ 0x8d) : {1'b0,x[7:1]}.
  - The Rcon sequence is 0x36, 0x1b, 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, used for rounds 10..1.
- SubWord uses the FIPS-197 forward S-box: one lookup function, applied to each of the 4 bytes.
- The state-update path needs a single SubWord instance. The FWD and inverse steps never occur in the same cycle, so they may share it.
- load_valid is ignored outside IDLE. load_ready = 0 in FWD and EMIT.
- Stall: while key_valid & !key_ready, round_key, round_idx and key_last hold stable.

## Timing
- Reset values:
  - State IDLE.
  - load_ready = 1.
  - key_valid = 0, key_last = 0.
  - round_key = 0, round_idx = 0.
  - Internal rcon = 0.
- Reset mid-FWD or mid-EMIT aborts immediately. key_valid drops the cycle after reset is sampled, and no partial key is emitted.
- Latency from accepted load:
  - load_is_final = 1: key_valid at cycle +1.
  - load_is_final = 0: FWD takes 10 cycles; key_valid at cycle +11.
- Throughput in EMIT: one key per cycle while key_ready = 1. All 11 keys take 11 cycles.
- After the round-0 handshake: key_valid = 0 and load_ready = 1 in the next cycle. The earliest next load is accepted in that cycle.
- Simultaneous reset and load_valid: reset wins and the load is not accepted.

## Test plan
- Load the FIPS-197 A.1 cipher key 2b7e151628aed2a6abf7158809cf4f3c (load_is_final = 0), key_ready = 1.
  - key_valid rises 11 cycles after acceptance.
  - First output: round_idx = 10, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round_idx 1 gives a0fafe1788542cb123a339392a6c7605.
  - round_idx 0 gives 2b7e...4f3c, with key_last = 1.
- Load d014f9a8c9ee2589e13f0cc8b6630ca6 with load_is_final = 1.
  - The same 11 keys appear, starting 1 cycle after acceptance.
- Backpressure: hold key_ready = 0 for 5 cycles at round_idx 7.
  - round_key stays constant and key_valid stays 1.
  - The sequence resumes correctly and the Rcon is not skipped.
- Assert load_valid during FWD and during EMIT.
  - load_ready = 0 and the sequence is unaffected.
- Assert reset at FWD step 4, then again at EMIT round 6.
  - All outputs return to reset values next cycle.
  - A subsequent load produces the full correct sequence.
- Back-to-back loads: a load asserted in the cycle after the round-0 handshake is accepted, and its sequence is correct.
